// File: rtl/bp_pkg.sv
// Shared branch-prediction constants: queue defaults and predictor-stage encodings.
package bp_pkg;
  localparam int BRQ_DEPTH = 4;
  localparam int BRQ_CNT_W = 16;

  // Predictor-stage table geometry and 2-bit counter encoding
  localparam int PHT_IDX_W = 10;
  typedef enum logic [1:0] {
    CTR_SNT = 2'd0,
    CTR_WNT = 2'd1,
    CTR_WT  = 2'd2,
    CTR_ST  = 2'd3
  } bp_ctr_e;
endpackage

// File: rtl/bp_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module bp_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] value
);
  logic [W-1:0] r_value;

  always_ff @(posedge clk) begin
    if (rst)                     r_value <= '0;
    else if (inc && r_value != '1) r_value <= r_value + 1'b1;
  end

  assign value = r_value;
endmodule

// File: rtl/branch_resolve_queue.sv
// FIFO of outstanding branch predictions, resolved in order; drives predictor
// update strobes, a flush pulse on mispredict, and saturating statistics.
module branch_resolve_queue
  import bp_pkg::*;
#(
  parameter int DEPTH = BRQ_DEPTH,
  parameter int CNT_W = BRQ_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pred_valid,
  input  logic                       pred_taken,
  output logic                       pred_ready,
  input  logic                       res_valid,
  input  logic                       res_taken,
  output logic                       upd_request,
  output logic                       upd_result,
  output logic                       mispredict,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [CNT_W-1:0]           branch_count,
  output logic [CNT_W-1:0]           mispredict_count,
  output logic                       underflow_err
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] r_mem;
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [OCC_W-1:0] r_occ;
  logic             r_upd_req, r_upd_res, r_mis, r_uf;

  logic w_acc, w_pop, w_empty, w_head, w_mis;

  assign w_empty    = (r_occ == '0);
  assign pred_ready = (r_occ < OCC_W'(DEPTH));
  assign w_acc      = pred_valid && pred_ready;
  assign w_pop      = res_valid && !w_empty;
  assign w_head     = r_mem[r_rptr];
  assign w_mis      = w_pop && (w_head != res_taken);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem     <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_occ     <= '0;
      r_upd_req <= 1'b0;
      r_upd_res <= 1'b0;
      r_mis     <= 1'b0;
      r_uf      <= 1'b0;
    end else begin
      r_upd_req <= w_pop;
      r_mis     <= w_mis;
      if (w_pop)                r_upd_res <= res_taken;
      if (res_valid && w_empty) r_uf      <= 1'b1;
      // A mispredict flushes everything younger, including a same-cycle push
      if (w_mis) begin
        r_occ  <= '0;
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_acc) begin
          r_mem[r_wptr] <= pred_taken;
          r_wptr        <= r_wptr + 1'b1;
        end
        if (w_pop) r_rptr <= r_rptr + 1'b1;
        if (w_acc && !w_pop)      r_occ <= r_occ + 1'b1;
        else if (!w_acc && w_pop) r_occ <= r_occ - 1'b1;
      end
    end
  end

  assign upd_request   = r_upd_req;
  assign upd_result    = r_upd_res;
  assign mispredict    = r_mis;
  assign occupancy     = r_occ;
  assign underflow_err = r_uf;

  bp_sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clk(clk), .rst(rst), .inc(w_pop), .value(branch_count)
  );

  bp_sat_counter #(.W(CNT_W)) u_mispred_cnt (
    .clk(clk), .rst(rst), .inc(w_mis), .value(mispredict_count)
  );
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Randomized and directed bench for branch_resolve_queue against a queue-based model.
module tb_branch_resolve_queue;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int MAXC  = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pred_valid = 1'b0, pred_taken = 1'b0, res_valid = 1'b0, res_taken = 1'b0;
  logic pred_ready, upd_request, upd_result, mispredict, underflow_err;
  logic [$clog2(DEPTH+1)-1:0] occupancy;
  logic [CNT_W-1:0] branch_count, mispredict_count;

  always #5 clk = ~clk;

  branch_resolve_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken),
    .upd_request(upd_request), .upd_result(upd_result), .mispredict(mispredict),
    .occupancy(occupancy), .branch_count(branch_count),
    .mispredict_count(mispredict_count), .underflow_err(underflow_err)
  );

  int n_tests = 0, n_fail = 0;

  // Reference model state
  bit mq[$];
  bit e_req, e_res, e_mis, e_uf;
  int e_bc, e_mc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    e_req = 0; e_res = 0; e_mis = 0; e_uf = 0; e_bc = 0; e_mc = 0;
  endtask

  task automatic model_step(input bit pv, pt, rv, rt, r);
    bit acc, head;
    if (r) begin
      model_reset();
      return;
    end
    acc   = pv && (mq.size() < DEPTH);
    e_req = 0;
    e_mis = 0;
    if (rv && mq.size() == 0) e_uf = 1;
    else if (rv) begin
      head  = mq.pop_front();
      e_req = 1;
      e_res = rt;
      if (e_bc < MAXC) e_bc++;
      if (head != rt) begin
        e_mis = 1;
        if (e_mc < MAXC) e_mc++;
        mq.delete();
        acc = 0;
      end
    end
    if (acc) mq.push_back(pt);
  endtask

  task automatic check_all();
    chk("occupancy", occupancy, mq.size());
    chk("upd_request", upd_request, e_req);
    chk("upd_result", upd_result, e_res);
    chk("mispredict", mispredict, e_mis);
    chk("underflow_err", underflow_err, e_uf);
    chk("branch_count", branch_count, e_bc);
    chk("mispredict_count", mispredict_count, e_mc);
  endtask

  task automatic step(input bit pv, pt, rv, rt, r);
    @(negedge clk);
    rst = r; pred_valid = pv; pred_taken = pt; res_valid = rv; res_taken = rt;
    #1 chk("pred_ready", pred_ready, (mq.size() < DEPTH));
    @(posedge clk);
    #1;
    model_step(pv, pt, rv, rt, r);
    check_all();
  endtask

  function automatic bit head_or0();
    return (mq.size() != 0) ? mq[0] : 1'b0;
  endfunction

  initial begin
    // Power-on reset
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("reset_pred_ready", pred_ready, 1);

    // In-order correct resolution: T,N,T
    step(0,0,0,0,1);
    step(1,1,0,0,0); step(1,0,0,0,0); step(1,1,0,0,0);
    step(0,0,1,1,0); step(0,0,1,0,0); step(0,0,1,1,0);
    step(0,0,0,0,0);
    chk("s1_bc", branch_count, 3);
    chk("s1_occ", occupancy, 0);
    chk("s1_mc", mispredict_count, 0);

    // Mispredict on first of T,T,T flushes the rest
    step(0,0,0,0,1);
    step(1,1,0,0,0); step(1,1,0,0,0); step(1,1,0,0,0);
    step(0,0,1,0,0);
    chk("s2_mis_pulse", mispredict, 1);
    chk("s2_occ", occupancy, 0);
    step(0,0,0,0,0);
    chk("s2_mis_clear", mispredict, 0);
    chk("s2_mc", mispredict_count, 1);

    // Full queue: same-cycle correct pop does not open a slot
    step(0,0,0,0,1);
    step(1,1,0,0,0); step(1,0,0,0,0); step(1,1,0,0,0); step(1,0,0,0,0);
    step(1,1,1,1,0);
    chk("s3_occ", occupancy, 3);

    // Resolve on empty with simultaneous push
    step(0,0,0,0,1);
    step(1,1,1,0,0);
    chk("s4_uf", underflow_err, 1);
    chk("s4_occ", occupancy, 1);
    chk("s4_req", upd_request, 0);

    // Ten correct push/pop pairs wrap the pointers
    step(0,0,0,0,1);
    step(1,1,0,0,0);
    for (int i = 0; i < 10; i++) step(1, $urandom_range(0,1), 1, head_or0(), 0);
    chk("s5_bc", branch_count, 10);
    chk("s5_occ", occupancy, 1);

    // Reset overrides an in-flight pop
    step(0,0,0,0,1);
    step(1,1,0,0,0); step(1,0,0,0,0);
    step(1,1,1,head_or0(),1);
    chk("s6_req", upd_request, 0);
    chk("s6_occ", occupancy, 0);
    chk("s6_ready", pred_ready, 1);

    // Random traffic; rare resets so counters reach saturation
    step(0,0,0,0,1);
    for (int i = 0; i < 3000; i++) begin
      bit pv, pt, rv, rt, r;
      pv = ($urandom_range(0,3) != 0);
      pt = $urandom_range(0,1);
      rv = ($urandom_range(0,2) != 0);
      rt = ($urandom_range(0,4) != 0) ? head_or0() : 1'($urandom_range(0,1));
      r  = ($urandom_range(0,999) == 0);
      step(pv, pt, rv, rt, r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
